// File: rtl/twiddle_addr_seq.sv
// twiddle_addr_seq: paired twiddle-ROM address sequencer for the recover-2N FFT.
// On an accepted start it walks k = 0..N/2 and drives addr_col1 = k*stride and
// addr_col2 = (N-k)*stride mod 2^ADDR_W. A ROM_LAT-deep tag pipeline carries
// {valid, last, k} so dv / k_o / done line up with the ROM data output.
// Optional feature: define TWIDDLE_ADDR_ABORT_EN to add the abort input.
//
// Handshake: valid is a one-cycle ROM read enable per issued k; stall=1 in RUN
// withholds the next issue (valid=0, k held). dv rises exactly ROM_LAT cycles
// after its valid and is never back-pressured.
module twiddle_addr_seq #(
  parameter int ADDR_W  = 11,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        len_log2,
  input  logic              stall,
`ifdef TWIDDLE_ADDR_ABORT_EN
  input  logic              abort,
`endif
  output logic              valid,
  output logic [ADDR_W-1:0] addr_col1,
  output logic [ADDR_W-1:0] addr_col2,
  output logic              dv,
  output logic [ADDR_W-1:0] k_o,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

  localparam logic [ADDR_W:0] N_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [3:0]      AW4   = 4'(ADDR_W);

  state_t r_state;
  state_t w_state_nxt;

  logic              w_accept;
  logic              w_issue;
  logic              w_flush;
  logic              w_cfg_err_nxt;
  logic              w_abort;
  logic              w_len_ok;
  logic [ADDR_W:0]   w_a1;
  logic [ADDR_W:0]   w_a2;
  logic [ADDR_W-1:0] w_half_new;
  logic              w_tag_last;

  logic [3:0]        r_shift;
  logic [ADDR_W-1:0] r_half;
  logic [ADDR_W-1:0] r_k;        // next k to issue
  logic [ADDR_W-1:0] r_issue_k;  // k currently presented with valid
  logic              r_valid;
  logic [ADDR_W-1:0] r_addr1;
  logic [ADDR_W-1:0] r_addr2;
  logic              r_cfg_err;
  logic              r_pv [ROM_LAT];
  logic              r_pl [ROM_LAT];
  logic [ADDR_W-1:0] r_pk [ROM_LAT];

`ifdef TWIDDLE_ADDR_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_len_ok   = (len_log2 >= 4'd2) && (len_log2 <= AW4);
  assign w_half_new = {{(ADDR_W-1){1'b0}}, 1'b1} << (len_log2 - 4'd1);
  assign w_a1       = {1'b0, r_k} << r_shift;
  assign w_a2       = N_MAX - w_a1;
  assign w_tag_last = r_valid && (r_issue_k == r_half);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and per-cycle control decisions
  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_issue       = 1'b0;
    w_flush       = 1'b0;
    w_cfg_err_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_len_ok) begin
            w_accept    = 1'b1;
            w_state_nxt = S_RUN;
          end else begin
            w_cfg_err_nxt = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (w_abort) begin
          w_flush     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (!stall) begin
          w_issue = 1'b1;
          if (r_k == r_half) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_abort) begin
          w_flush     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_pl[ROM_LAT-1]) begin
          // final tag is on the output this cycle; pipeline is empty after it
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Address issue registers: k=0 goes out on the accepting edge itself
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift   <= '0;
      r_half    <= '0;
      r_k       <= '0;
      r_issue_k <= '0;
      r_valid   <= 1'b0;
      r_addr1   <= '0;
      r_addr2   <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_cfg_err_nxt;
      if (w_accept) begin
        r_shift   <= AW4 - len_log2;
        r_half    <= w_half_new;
        r_k       <= ADDR_W'(1);
        r_issue_k <= '0;
        r_valid   <= 1'b1;
        r_addr1   <= '0;
        r_addr2   <= '0;
      end else if (w_issue) begin
        r_issue_k <= r_k;
        r_k       <= r_k + ADDR_W'(1);
        r_valid   <= 1'b1;
        r_addr1   <= w_a1[ADDR_W-1:0];
        r_addr2   <= w_a2[ADDR_W-1:0];
      end else begin
        r_valid   <= 1'b0;
      end
    end
  end

  // Tag pipeline: delays {valid, last, k} to match the ROM read latency
  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        r_pv[i] <= 1'b0;
        r_pl[i] <= 1'b0;
        r_pk[i] <= '0;
      end
    end else begin
      r_pv[0] <= r_valid;
      r_pl[0] <= w_tag_last;
      r_pk[0] <= r_issue_k;
      for (int i = 1; i < ROM_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pl[i] <= r_pl[i-1];
        r_pk[i] <= r_pk[i-1];
      end
    end
  end

  assign valid     = r_valid;
  assign addr_col1 = r_addr1;
  assign addr_col2 = r_addr2;
  assign dv        = r_pv[ROM_LAT-1];
  assign k_o       = r_pk[ROM_LAT-1];
  assign done      = r_pl[ROM_LAT-1];
  assign busy      = (r_state != S_IDLE);
  assign cfg_err   = r_cfg_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_twiddle_addr_seq.sv
// Bench for twiddle_addr_seq (ADDR_W=11, ROM_LAT=1).
module tb_twiddle_addr_seq;

  localparam int W = 11;

  logic         clk;
  logic         rst;
  logic         start;
  logic [3:0]   len_log2;
  logic         stall;
`ifdef TWIDDLE_ADDR_ABORT_EN
  logic         abort;
`endif
  logic         valid;
  logic [W-1:0] addr_col1;
  logic [W-1:0] addr_col2;
  logic         dv;
  logic [W-1:0] k_o;
  logic         busy;
  logic         done;
  logic         cfg_err;
  logic [1:0]   dbg_state;

  logic [2*W-1:0] exp_q[$];    // {addr_col1, addr_col2} per expected valid
  logic [W:0]     exp_d_q[$];  // {done, k} per expected dv

  int total = 0;
  int bad   = 0;
  int n_valid = 0;
  logic prev_valid = 1'b0;

  twiddle_addr_seq #(.ADDR_W(W), .ROM_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .len_log2(len_log2), .stall(stall),
`ifdef TWIDDLE_ADDR_ABORT_EN
    .abort(abort),
`endif
    .valid(valid), .addr_col1(addr_col1), .addr_col2(addr_col2), .dv(dv),
    .k_o(k_o), .busy(busy), .done(done), .cfg_err(cfg_err), .dbg_state(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // monitor: pops the scoreboard whenever the DUT presents valid or dv
  always @(negedge clk) begin
    logic [2*W-1:0] ea;
    logic [W:0]     ed;
    if (valid === 1'b1) begin
      n_valid++;
      chk("valid_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        ea = exp_q.pop_front();
        chk("addr_col1", 32'(addr_col1), 32'(ea[2*W-1:W]));
        chk("addr_col2", 32'(addr_col2), 32'(ea[W-1:0]));
      end
    end
    if (dv === 1'b1) begin
      chk("dv_expected", 32'(exp_d_q.size() != 0), 32'd1);
      chk("dv_latency", 32'(prev_valid), 32'd1);
      if (exp_d_q.size() != 0) begin
        ed = exp_d_q.pop_front();
        chk("k_o", 32'(k_o), 32'(ed[W-1:0]));
        chk("done", 32'(done), 32'(ed[W]));
      end
    end else if (done === 1'b1) begin
      chk("done_without_dv", 32'(dv), 32'd1);
    end
    prev_valid = valid;
  end

  // scoreboard fill from the address formula
  task automatic push_run(input int l);
    int n;
    logic [W:0] a1;
    logic [W:0] a2;
    n = 1 << l;
    for (int k = 0; k <= n / 2; k++) begin
      a1 = (W+1)'(k << (W - l));
      a2 = (W+1)'(2048) - a1;
      exp_q.push_back({a1[W-1:0], a2[W-1:0]});
      exp_d_q.push_back({(k == n / 2), W'(k)});
    end
  endtask

  // scoreboard fill from the hand-computed N=16 table
  task automatic push_len4_table();
    int t1 [9];
    int t2 [9];
    t1 = '{0, 128, 256, 384, 512, 640, 768, 896, 1024};
    t2 = '{0, 1920, 1792, 1664, 1536, 1408, 1280, 1152, 1024};
    for (int k = 0; k < 9; k++) begin
      exp_q.push_back({W'(t1[k]), W'(t2[k])});
      exp_d_q.push_back({(k == 8), W'(k)});
    end
  endtask

  // called at a negedge; returns at the negedge where k=0 should be visible
  task automatic do_start(input logic [3:0] l);
    n_valid = 0;
    start = 1'b1;
    len_log2 = l;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("valid_after_start", 32'(valid), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd1);
    @(negedge clk);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("state_idle", 32'(dbg_state), 32'd0);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("exp_d_q_empty", 32'(exp_d_q.size()), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_addr_col1"}, 32'(addr_col1), 32'd0);
    chk({tag, "_addr_col2"}, 32'(addr_col2), 32'd0);
    chk({tag, "_dv"}, 32'(dv), 32'd0);
    chk({tag, "_k_o"}, 32'(k_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_cfg_err"}, 32'(cfg_err), 32'd0);
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    start = 1'b0;
    len_log2 = 4'd4;
    stall = 1'b0;
`ifdef TWIDDLE_ADDR_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    chk("reset_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // N=16, no stall: 9 issues from the hand table
    push_len4_table();
    do_start(4'd4);
    wait_done(40);
    chk("len4_issues", 32'(n_valid), 32'd9);

    // start in the cycle after done: N=2048 with a 3-cycle stall after the 5th issue
    push_run(11);
    do_start(4'd11);
    cnt = 1;
    while (cnt < 5) begin
      @(negedge clk);
      if (valid === 1'b1) cnt++;
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid_low", 32'(valid), 32'd0);
    end
    stall = 1'b0;
    wait_done(1200);
    chk("len11_issues", 32'(n_valid), 32'd1025);

    // illegal lengths
    for (int i = 0; i < 2; i++) begin
      start = 1'b1;
      len_log2 = (i == 0) ? 4'd1 : 4'd12;
      @(negedge clk);
      start = 1'b0;
      chk("cfg_err_pulse", 32'(cfg_err), 32'd1);
      chk("cfg_err_busy", 32'(busy), 32'd0);
      chk("cfg_err_valid", 32'(valid), 32'd0);
      @(negedge clk);
      chk("cfg_err_clear", 32'(cfg_err), 32'd0);
      chk("cfg_err_idle", 32'(busy), 32'd0);
    end

    // reset at the 4th cycle of an N=32 run
    push_run(5);
    do_start(4'd5);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    exp_d_q.delete();
    @(negedge clk);
    chk_all_zero("midrst");
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_no_done", 32'(done), 32'd0);

    // start together with reset: reset wins
    rst = 1'b1;
    start = 1'b1;
    len_log2 = 4'd5;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    chk("rst_start_busy", 32'(busy), 32'd0);
    chk("rst_start_valid", 32'(valid), 32'd0);
    @(negedge clk);

    // new run after reset restarts at k=0
    push_run(5);
    do_start(4'd5);
    wait_done(40);
    chk("len5_issues", 32'(n_valid), 32'd17);

    // start while busy is ignored
    push_run(3);
    do_start(4'd3);
    start = 1'b1;
    len_log2 = 4'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done(20);
    chk("len3_issues", 32'(n_valid), 32'd5);

`ifdef TWIDDLE_ADDR_ABORT_EN
    // abort while k=3 is being issued
    push_run(4);
    do_start(4'd4);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    exp_d_q.delete();
    @(negedge clk);
    abort = 1'b0;
    chk("abort_valid", 32'(valid), 32'd0);
    chk("abort_dv", 32'(dv), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
    end
    chk("abort_issues", 32'(n_valid), 32'd4);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
